// File: rtl/fetch_pkg.sv
// Shared widths, alignment helpers and the buffered fetch entry type
// used by the fetch unit and its instruction buffer.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP    = 32'd4;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer with flush; the head entry is
// presented combinationally and reads as zero while the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same edge, so a full buffer can still accept.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!flush_i && do_push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, captures same-cycle ROM
// data into a small buffer and serves decode; redirects flush and retarget.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              push;
    fetch_entry_t      head;
    fetch_entry_t      new_entry;

    assign pop       = !fifo_empty && out_ready;
    // Redirect wins over fetching: the word at the old PC is never buffered.
    assign push      = fetch_en && !redirect_valid && (!fifo_full || pop);
    assign new_entry = '{pc: pc_q, instr: imem_data};

    assign imem_addr = pc_q;
    assign out_valid = (fifo_count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_data_i(new_entry),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequence and a
// randomized run checked against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA000_0000 + (addr >> 2);
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = eaddr;
        return v;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;

    initial begin
        vec_t tbl[22];

        // stream
        tbl[0]  = mk(1, 1, 0, 32'h0,         1, 32'h0,         32'h4);
        tbl[1]  = mk(1, 1, 0, 32'h0,         1, 32'h4,         32'h8);
        tbl[2]  = mk(1, 1, 0, 32'h0,         1, 32'h8,         32'hC);
        tbl[3]  = mk(1, 1, 0, 32'h0,         1, 32'hC,         32'h10);
        // restart at 0, then backpressure until full
        tbl[4]  = mk(1, 0, 1, 32'h0,         0, 32'h0,         32'h0);
        tbl[5]  = mk(1, 0, 0, 32'h0,         1, 32'h0,         32'h4);
        tbl[6]  = mk(1, 0, 0, 32'h0,         1, 32'h0,         32'h8);
        tbl[7]  = mk(1, 0, 0, 32'h0,         1, 32'h0,         32'h8);
        tbl[8]  = mk(1, 1, 0, 32'h0,         1, 32'h4,         32'hC);
        tbl[9]  = mk(1, 1, 0, 32'h0,         1, 32'h8,         32'h10);
        // redirect while full, then misaligned redirect
        tbl[10] = mk(1, 0, 1, 32'h40,        0, 32'h0,         32'h40);
        tbl[11] = mk(1, 1, 0, 32'h0,         1, 32'h40,        32'h44);
        tbl[12] = mk(1, 1, 1, 32'h43,        0, 32'h0,         32'h40);
        tbl[13] = mk(1, 1, 0, 32'h0,         1, 32'h40,        32'h44);
        tbl[14] = mk(1, 1, 0, 32'h0,         1, 32'h44,        32'h48);
        // fetch_en gating
        tbl[15] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h48);
        tbl[16] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h48);
        tbl[17] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h48);
        tbl[18] = mk(1, 1, 0, 32'h0,         1, 32'h48,        32'h4C);
        // address wrap
        tbl[19] = mk(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC);
        tbl[20] = mk(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);
        tbl[21] = mk(1, 1, 0, 32'h0,         1, 32'h0,         32'h4);

        // reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_addr",  imem_addr, RESET_PC & 32'hFFFF_FFFC);
        chk("rst_pc",    out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        rst = 1'b0;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < 22; i++) begin
            fetch_en       = tbl[i].en;
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_instr", i), out_instr, mem_word(tbl[i].exp_pc));
            end
            $display("vec %0d en=%b rdy=%b rv=%b rpc=%h -> valid=%b pc=%h instr=%h addr=%h",
                     i, tbl[i].en, tbl[i].rdy, tbl[i].rv, tbl[i].rpc,
                     out_valid, out_pc, out_instr, imem_addr);
        end

        // async reset between edges with one entry buffered
        out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_addr",  imem_addr, RESET_PC & 32'hFFFF_FFFC);
        chk("async_rst_pc",    out_pc, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        $display("async reset: valid=%b addr=%h", out_valid, imem_addr);
        rst = 1'b0;

        // randomized run against the reference model
        mq.delete();
        mpc = RESET_PC & 32'hFFFF_FFFC;
        for (int c = 0; c < 400; c++) begin
            logic mpop;
            logic mpush;
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : $urandom;
            mpop  = (mq.size() > 0) && out_ready;
            mpush = fetch_en && !redirect_valid && ((mq.size() < DEPTH) || mpop);
            @(posedge clk);
            if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (mpush) begin
                    mq.push_back('{pc: mpc, instr: mem_word(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
            #1;
            redirect_valid = 1'b0;
            chk("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("rnd_addr", imem_addr, mpc);
            if (mq.size() > 0) begin
                chk("rnd_pc", out_pc, mq[0].pc);
                chk("rnd_instr", out_instr, mq[0].instr);
            end
            $display("rnd %0d valid=%b pc=%h instr=%h addr=%h depth=%0d",
                     c, out_valid, out_pc, out_instr, imem_addr, mq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the fetch PC, drives the word-aligned byte address to the instruction ROM and captures the returned word (combinational, same-cycle read).
- Buffers fetched instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the FIFO.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  when 0, no new fetches are issued; the buffer still drains.
- imem_addr  output  32  byte address to instruction memory, always equal to fetch_pc, low 2 bits always 0.
- imem_data  input  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  input  1  one-cycle pulse: a taken branch or jump.
- redirect_pc  input  32  new fetch target; bits [1:0] are ignored.
- out_valid  output  1  buffer head is valid.
- out_ready  input  1  decode accepts the head.
- out_instr  output  32  instruction at the buffer head.
- out_pc  output  32  PC of out_instr.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC with [1:0] forced to 0.
  - FIFO is empty: count = 0, pointers = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0.
  - imem_addr = RESET_PC & ~3.
- Pop: out_valid && out_ready at a rising edge. The head is removed.
- Push condition: fetch_en && !redirect_valid && (count < DEPTH || pop).
  - On push at the edge, the FIFO writes {fetch_pc, imem_data} and fetch_pc <= fetch_pc + 4.
- Push and pop in the same cycle:
  - Legal when full and when empty.
  - When empty, the pushed entry appears at the head in the next cycle. There is no bypass: the earliest out_valid is 1 cycle after the capture edge.
- Latency:
  - After rst deasserts with fetch_en = 1, the first edge captures the word at RESET_PC and out_valid = 1 from that edge onward.
  - Steady state with out_ready = 1 is one instruction per cycle.
- Redirect (highest priority):
  - At the edge where redirect_valid = 1, fetch_pc <= {redirect_pc[31:2], 2'b00} and the FIFO is flushed (count = 0).
  - No push happens that cycle.
  - A pop that is presented in the same cycle still counts as delivered to decode. Execute is responsible for squashing it.
  - The next cycle fetches from the new target, and out_valid returns 1 cycle after that.
- Full (count == DEPTH) with no pop: fetch_pc holds and imem_addr is stable.
- fetch_en = 0: fetch_pc holds and no push occurs. A redirect is still honoured.
- Wrap-around: fetch_pc + 4 wraps modulo 2^32 with no flag. FIFO pointers wrap modulo DEPTH.
- out_instr and out_pc always reflect the head entry; their value is don't-care when out_valid = 0.
- Once out_valid is 1 it stays 1 until a pop, redirect, or reset. The head never changes while not popped.
- Reset mid-operation: all state returns to the reset values within the same cycle, independent of clk.

Decomposition:
- Shared package fetch_pkg holds:
  - INSTR_W = 32, ADDR_W = 32, PC_STEP = 4.
  - The alignment mask ALIGN_MASK = 32'hFFFF_FFFC.
  - Entry type fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO with parameter DEPTH, a flush input, push/pop, full/empty/count outputs, and the same asynchronous active-high reset.
- fetch_unit holds the PC register, the push/pop control and the redirect priority.

Test Plan:
- Reset and stream: memory word i = 32'hA000_0000 + i, RESET_PC = 0, out_ready = 1.
  - Expect out_pc 0, 4, 8, 12 on consecutive cycles with out_instr A0000000, A0000001, …
  - Expect out_valid = 0 during rst and in the first cycle after it.
- Backpressure: hold out_ready = 0.
  - After 2 cycles count = 2 and imem_addr holds at 8.
  - Raise out_ready: expect pcs 0, 4, 8 with no loss or duplication.
- Redirect while full: with count = 2, pulse redirect_valid with redirect_pc = 32'h40.
  - Next cycle out_valid = 0 and imem_addr = 0x40.
  - The following cycle out_pc = 0x40.
- Misaligned redirect: redirect_pc = 32'h43 → imem_addr = 0x40 and out_pc = 0x40.
- fetch_en gating: drop fetch_en for 3 cycles with out_ready = 1.
  - The FIFO drains, imem_addr is frozen and out_valid goes to 0.
  - On re-enable, fetching resumes at the frozen address.
- Reset mid-stream: assert rst between clock edges while count = 1.
  - out_valid falls immediately and imem_addr = RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC → out_pc sequence FFFFFFFC, 00000000.
